// File: rtl/morse_pkg.sv
// morse_pkg: Morse pattern/length constants shared with the transmitter, plus receiver state encoding
package morse_pkg;
  localparam int MAX_ELEMS = 5;
  localparam int LEN_W = 3;
  localparam logic ELEM_DOT = 1'b0;
  localparam logic ELEM_DASH = 1'b1;
  typedef enum logic [1:0] {IDLE, MARK, SPACE, WAIT_WORD} rx_state_e;
endpackage

// File: rtl/key_sync_edge.sv
// key_sync_edge: 2-flop synchronizer for the raw keying line with single-cycle rise/fall strobes
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_s,
  output logic rise,
  output logic fall
);
  logic meta, key_d;
  // Chain resets high so a key held through reset is not seen as a fresh rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {meta, key_s, key_d} <= '1;
    else {meta, key_s, key_d} <= {key, meta, key_s};
  assign rise = key_s & ~key_d;
  assign fall = ~key_s & key_d;
endmodule

// File: rtl/signal_to_morse.sv
// signal_to_morse: times marks/spaces on a keying line and assembles one Morse character
module signal_to_morse
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES    = 5_000_000,
  parameter int GLITCH_CYCLES  = 1_000,
  parameter int DASH_MIN_UNITS = 2,
  parameter int CHAR_GAP_UNITS = 2,
  parameter int WORD_GAP_UNITS = 6
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Key,
  output logic [MAX_ELEMS-1:0] o_Morse_Pattern,
  output logic [LEN_W-1:0]     o_Morse_Length,
  output logic                 o_Valid,
  output logic                 o_Error,
  output logic                 o_Word_Gap,
  output logic                 o_Busy
);
  localparam int CNT_MAX = WORD_GAP_UNITS * UNIT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SAT = CW'(CNT_MAX);
  localparam logic [CW-1:0] CHAR_LAST = CW'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] DASH_MIN = CW'(DASH_MIN_UNITS * UNIT_CYCLES);
  localparam logic [CW-1:0] GLITCH = CW'(GLITCH_CYCLES);
  rx_state_e state, state_nxt;
  logic key_s, rise, fall, emit, word, err, err_nxt;
  logic [CW-1:0] cnt, cnt_nxt, dur, spc, spc_nxt;
  logic [MAX_ELEMS-1:0] sr, sr_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  key_sync_edge u_sync (.clk(i_Clock), .rst_n(i_Rst_n), .key(i_Key), .key_s(key_s), .rise(rise), .fall(fall));
  // dur is the length of the current mark/space including this cycle
  assign dur = (cnt == SAT) ? cnt : cnt + 1'b1;
  always_comb begin
    state_nxt = state;
    cnt_nxt = dur;
    spc_nxt = spc;
    sr_nxt = sr;
    len_nxt = len;
    err_nxt = err;
    emit = 1'b0;
    word = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_nxt = MARK;
        cnt_nxt = '0;
      end
      MARK: if (fall) begin
        if (dur < GLITCH) begin
          state_nxt = (len != '0) ? SPACE : IDLE;
          cnt_nxt = spc;
        end else begin
          state_nxt = SPACE;
          cnt_nxt = '0;
          if (len == LEN_W'(MAX_ELEMS)) err_nxt = 1'b1;
          else begin
            sr_nxt[len] = (dur >= DASH_MIN) ? ELEM_DASH : ELEM_DOT;
            len_nxt = len + 1'b1;
          end
        end
      end
      SPACE: begin
        if (cnt == CHAR_LAST) begin
          emit = 1'b1;
          sr_nxt = '0;
          len_nxt = '0;
          err_nxt = 1'b0;
          state_nxt = WAIT_WORD;
        end
        // SPACE is only entered with the key low, so a high level here is the rise
        if (key_s) begin
          state_nxt = MARK;
          cnt_nxt = '0;
          spc_nxt = cnt;
        end
      end
      WAIT_WORD: if (rise) begin
        state_nxt = MARK;
        cnt_nxt = '0;
      end else if (cnt == WORD_LAST) begin
        word = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      cnt <= '0;
      spc <= '0;
      sr <= '0;
      len <= '0;
      err <= 1'b0;
      o_Morse_Pattern <= '0;
      o_Morse_Length <= '0;
      o_Error <= 1'b0;
      o_Valid <= 1'b0;
      o_Word_Gap <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      spc <= spc_nxt;
      sr <= sr_nxt;
      len <= len_nxt;
      err <= err_nxt;
      o_Valid <= emit;
      o_Word_Gap <= word;
      if (emit) begin
        o_Morse_Pattern <= sr;
        o_Morse_Length <= len;
        o_Error <= err;
      end
    end
  assign o_Busy = (state == MARK) | (state == SPACE);
endmodule

// File: tb/tb_signal_to_morse.sv
// tb_signal_to_morse: directed keying sequences with a scoreboard of expected characters
module tb_signal_to_morse;
  typedef struct {logic [4:0] pat; logic [2:0] len; logic err; int at;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, key = 1'b0;
  logic [4:0] pat;
  logic [2:0] len;
  logic valid, err, word, busy;
  int compared = 0, mismatched = 0, cyc = 0, fall_ref = 0;
  int n_valid = 0, n_word = 0, word_cyc = 0, w0 = 0, v0 = 0;
  exp_t sb[$];
  exp_t e;

  signal_to_morse #(
    .UNIT_CYCLES(10), .GLITCH_CYCLES(3), .DASH_MIN_UNITS(2), .CHAR_GAP_UNITS(2), .WORD_GAP_UNITS(6)
  ) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Key(key),
    .o_Morse_Pattern(pat), .o_Morse_Length(len), .o_Valid(valid),
    .o_Error(err), .o_Word_Gap(word), .o_Busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      check("unexpected_valid", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pattern", pat, e.pat);
        check("length", len, e.len);
        check("error", err, e.err);
        if (e.at != 0) check("valid_cycle", cyc, e.at);
      end
    end
    if (word) begin
      n_word++;
      word_cyc = cyc;
    end
  end

  task automatic hold(input logic lvl, input int n);
    key = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // fall_ref is the first clock edge that samples the key low
  task automatic mark(input int n);
    hold(1'b1, n);
    key = 1'b0;
    fall_ref = cyc + 1;
  endtask

  task automatic expect_char(input logic [4:0] p, input logic [2:0] l, input logic er, input int lat);
    exp_t x;
    x.pat = p;
    x.len = l;
    x.err = er;
    x.at = (lat != 0) ? fall_ref + lat : 0;
    sb.push_back(x);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pattern", pat, 0);
    check("rst_length", len, 0);
    check("rst_valid", valid, 0);
    check("rst_error", err, 0);
    check("rst_word", word, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // F = ..-.
    w0 = n_word;
    mark(10); hold(0, 10); mark(10); hold(0, 10); mark(30); hold(0, 10); mark(10);
    expect_char(5'b00100, 3'd4, 1'b0, 22);
    hold(0, 5);
    check("busy_space", busy, 1);
    hold(0, 75);
    drain("drain_F");
    check("word_count_F", n_word - w0, 1);
    check("word_cycle_F", word_cyc, fall_ref + 62);
    check("busy_idle_F", busy, 0);
    // T then E with a 3-unit gap: no word gap between them
    w0 = n_word;
    mark(30);
    expect_char(5'b00001, 3'd1, 1'b0, 22);
    hold(0, 30);
    mark(10);
    expect_char(5'b00000, 3'd1, 1'b0, 22);
    hold(0, 30);
    check("no_word_TE", n_word - w0, 0);
    hold(0, 50);
    drain("drain_TE");
    check("word_count_TE", n_word - w0, 1);
    check("word_cycle_TE", word_cyc, fall_ref + 62);
    // six elements: overflow freezes pattern at five and flags error
    for (int i = 0; i < 6; i++) begin
      mark((i % 2 != 0) ? 30 : 10);
      if (i < 5) hold(0, 10);
    end
    expect_char(5'b01010, 3'd5, 1'b1, 22);
    hold(0, 80);
    drain("drain_overflow");
    // glitch inside an intra-character gap
    mark(10); hold(0, 4); mark(2); hold(0, 4); mark(10);
    expect_char(5'b00000, 3'd2, 1'b0, 22);
    hold(0, 80);
    drain("drain_glitch");
    // glitch while idle
    v0 = n_valid;
    w0 = n_word;
    mark(2);
    hold(0, 40);
    check("idle_glitch_valid", n_valid - v0, 0);
    check("idle_glitch_word", n_word - w0, 0);
    check("idle_glitch_busy", busy, 0);
    // reset in the middle of the dash of A, key held through reset
    mark(10); hold(0, 10); hold(1, 10);
    check("busy_mark", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pattern", pat, 0);
    check("mid_rst_length", len, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_error", err, 0);
    check("mid_rst_word", word, 0);
    check("mid_rst_busy", busy, 0);
    v0 = n_valid;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1, 30);
    check("held_key_busy", busy, 0);
    hold(0, 10);
    check("after_fall_busy", busy, 0);
    check("no_valid_after_rst", n_valid - v0, 0);
    mark(10);
    expect_char(5'b00000, 3'd1, 1'b0, 22);
    hold(0, 30);
    drain("drain_post_rst");
    // mark boundary: 19 cycles dot, 20 cycles dash
    mark(19); hold(0, 10); mark(20);
    expect_char(5'b00010, 3'd2, 1'b0, 22);
    hold(0, 30);
    drain("drain_mark_bound");
    // space boundary: 19 continues the character
    mark(10); hold(0, 19); mark(10);
    expect_char(5'b00000, 3'd2, 1'b0, 22);
    hold(0, 30);
    drain("drain_space19");
    // space boundary: 20 emits, and the coincident rise opens a new character
    mark(10);
    expect_char(5'b00000, 3'd1, 1'b0, 22);
    hold(0, 20);
    mark(10);
    expect_char(5'b00000, 3'd1, 1'b0, 22);
    hold(0, 30);
    drain("drain_space20");
    // mark longer than the counter limit still reads as dash
    mark(70);
    expect_char(5'b00001, 3'd1, 1'b0, 22);
    hold(0, 30);
    drain("drain_saturate");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
